// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: generates register enables and bubble clears,
// freezes on outstanding memory accesses, flags memory timeouts, counts stall cycles.
module pipeline_stall_controller #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  ID_RN,
  input  logic [3:0]  ID_RM,
  input  logic        ID_USES_RN,
  input  logic        ID_USES_RM,
  input  logic        EX_LOAD,
  input  logic        EX_RF_ENABLE,
  input  logic [3:0]  EX_RD,
  input  logic        BRANCH_TAKEN,
  input  logic        MEM_ACCESS,
  input  logic        MEM_MOC,
  output logic        PC_ENABLE,
  output logic        IF_ID_ENABLE,
  output logic        ID_EX_ENABLE,
  output logic        EX_MEM_ENABLE,
  output logic        MEM_WB_ENABLE,
  output logic        IF_ID_CLEAR,
  output logic        ID_EX_CLEAR,
  output logic        MEM_FAULT,
  output logic [15:0] STALL_CYCLES
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FAULT} state_t;

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);
  localparam logic [9:0] TIMEOUT   = 10'(MEM_TIMEOUT);
  localparam logic [4:0] EN_ALL    = 5'b11111;
  localparam logic [4:0] EN_NONE   = 5'b00000;
  localparam logic [4:0] EN_BUBBLE = 5'b00111;

  state_t      state_q, state_d;
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_fault_q, mem_fault_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic        haz, mem_pend;
  logic [4:0]  en;  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
  logic        if_id_clr, id_ex_clr;

  always_comb begin
    haz = EX_LOAD & EX_RF_ENABLE &
          ((ID_USES_RN & (ID_RN == EX_RD)) | (ID_USES_RM & (ID_RM == EX_RD)));
    mem_pend       = MEM_ACCESS & ~MEM_MOC;
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_fault_d    = mem_fault_q;
    en             = EN_ALL;
    if_id_clr      = 1'b0;
    id_ex_clr      = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_pend) begin
          en         = EN_NONE;
          state_d    = MEM_WAIT;
          wait_cnt_d = 10'd1;
        end else if (haz) begin
          en        = EN_BUBBLE;
          id_ex_clr = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            state_d     = LOAD_STALL;
            stall_cnt_d = LU_RELOAD;
          end
        end else if (BRANCH_TAKEN) begin
          if_id_clr = 1'b1;
        end
      end
      LOAD_STALL: begin
        if (mem_pend) begin
          en         = EN_NONE;
          state_d    = MEM_WAIT;
          wait_cnt_d = 10'd1;
        end else begin
          en          = EN_BUBBLE;
          id_ex_clr   = 1'b1;
          stall_cnt_d = stall_cnt_q - 3'd1;
          if (stall_cnt_q <= 3'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!MEM_MOC) begin
          en         = EN_NONE;
          wait_cnt_d = wait_cnt_q + 10'd1;
          if (wait_cnt_q == TIMEOUT) begin
            state_d     = FAULT;
            mem_fault_d = 1'b1;
          end
        end else begin
          // Completion cycle decodes like RUN; an interrupted load stall resumes.
          wait_cnt_d = 10'd0;
          state_d    = RUN;
          if (haz) begin
            en        = EN_BUBBLE;
            id_ex_clr = 1'b1;
          end else if (BRANCH_TAKEN) begin
            if_id_clr = 1'b1;
          end
          if (stall_cnt_q != 3'd0) begin
            state_d = LOAD_STALL;
          end else if (haz && (LOAD_USE_CYCLES > 1)) begin
            state_d     = LOAD_STALL;
            stall_cnt_d = LU_RELOAD;
          end
        end
      end
      FAULT: begin
        en          = EN_NONE;
        mem_fault_d = 1'b1;
      end
      default: state_d = RUN;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (!en[4] && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= RUN;
      stall_cnt_q    <= 3'd0;
      wait_cnt_q     <= 10'd0;
      mem_fault_q    <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_fault_q    <= mem_fault_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Reset holds every register frozen and cleared regardless of state.
  assign PC_ENABLE     = en[4] & ~RESET;
  assign IF_ID_ENABLE  = en[3] & ~RESET;
  assign ID_EX_ENABLE  = en[2] & ~RESET;
  assign EX_MEM_ENABLE = en[1] & ~RESET;
  assign MEM_WB_ENABLE = en[0] & ~RESET;
  assign IF_ID_CLEAR   = if_id_clr | RESET;
  assign ID_EX_CLEAR   = id_ex_clr | RESET;
  assign MEM_FAULT     = mem_fault_q;
  assign STALL_CYCLES  = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller; four instances with
// different LOAD_USE_CYCLES / MEM_TIMEOUT share one stimulus stream.
module tb_pipeline_stall_controller;

  typedef struct packed {
    logic [4:0]  en;   // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic [1:0]  clr;  // {IF_ID_CLEAR, ID_EX_CLEAR}
    logic        flt;
    logic [15:0] stc;
  } exp_t;

  localparam logic [4:0] EN_ALL = 5'b11111, EN_NONE = 5'b00000, EN_HAZ = 5'b00111;
  localparam logic [1:0] CL_NONE = 2'b00, CL_RST = 2'b11, CL_IDEX = 2'b01, CL_IFID = 2'b10;

  logic       CLK, RESET;
  logic [3:0] ID_RN, ID_RM, EX_RD;
  logic       ID_USES_RN, ID_USES_RM, EX_LOAD, EX_RF_ENABLE, BRANCH_TAKEN, MEM_ACCESS, MEM_MOC;

  logic [4:0]  en_o  [4];
  logic [1:0]  clr_o [4];
  logic        flt_o [4];
  logic [15:0] stc_o [4];

  exp_t  sb [$];
  string tag_q [$];
  int    sel_q [$];
  int    n_checks = 0;
  int    n_err = 0;

  // 0: defaults, 1: LOAD_USE_CYCLES=3, 2: MEM_TIMEOUT=4, 3: MEM_TIMEOUT=1023
  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipeline_stall_controller #(
      .LOAD_USE_CYCLES(g == 1 ? 3 : 1),
      .MEM_TIMEOUT(g == 2 ? 4 : (g == 3 ? 1023 : 64))
    ) u_dut (
      .CLK(CLK), .RESET(RESET),
      .ID_RN(ID_RN), .ID_RM(ID_RM), .ID_USES_RN(ID_USES_RN), .ID_USES_RM(ID_USES_RM),
      .EX_LOAD(EX_LOAD), .EX_RF_ENABLE(EX_RF_ENABLE), .EX_RD(EX_RD),
      .BRANCH_TAKEN(BRANCH_TAKEN), .MEM_ACCESS(MEM_ACCESS), .MEM_MOC(MEM_MOC),
      .PC_ENABLE(en_o[g][4]), .IF_ID_ENABLE(en_o[g][3]), .ID_EX_ENABLE(en_o[g][2]),
      .EX_MEM_ENABLE(en_o[g][1]), .MEM_WB_ENABLE(en_o[g][0]),
      .IF_ID_CLEAR(clr_o[g][1]), .ID_EX_CLEAR(clr_o[g][0]),
      .MEM_FAULT(flt_o[g]), .STALL_CYCLES(stc_o[g])
    );
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    ID_RN = 4'd0; ID_RM = 4'd0; ID_USES_RN = 1'b0; ID_USES_RM = 1'b0;
    EX_LOAD = 1'b0; EX_RF_ENABLE = 1'b0; EX_RD = 4'd0;
    BRANCH_TAKEN = 1'b0; MEM_ACCESS = 1'b0; MEM_MOC = 1'b0;
  endtask

  task automatic set_haz_rn(input logic uses);
    EX_LOAD = 1'b1; EX_RF_ENABLE = 1'b1; EX_RD = 4'd3; ID_RN = 4'd3; ID_USES_RN = uses;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    idle();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Push the expectation for the cycle just driven, then sample and compare.
  task automatic chk(input int sel, input string tag, input logic [4:0] en,
                     input logic [1:0] clr, input logic flt, input logic [15:0] stc);
    exp_t e, o;
    string t;
    int s;
    e.en = en; e.clr = clr; e.flt = flt; e.stc = stc;
    sb.push_back(e);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    #2;
    e = sb.pop_front();
    t = tag_q.pop_front();
    s = sel_q.pop_front();
    o = {en_o[s], clr_o[s], flt_o[s], stc_o[s]};
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s[u%0d]: observed en=%b clr=%b flt=%b stall=%0d, expected en=%b clr=%b flt=%b stall=%0d",
             t, s, o.en, o.clr, o.flt, o.stc, e.en, e.clr, e.flt, e.stc);
    end
  endtask

  initial begin
    RESET = 1'b1;
    idle();

    // Reset behaviour
    @(negedge CLK);
    for (int i = 0; i < 4; i++) chk(i, "rst_hold", EN_NONE, CL_RST, 1'b0, 16'd0);
    @(negedge CLK);
    chk(0, "rst_hold2", EN_NONE, CL_RST, 1'b0, 16'd0);
    @(negedge CLK);
    RESET = 1'b0;
    chk(0, "rst_release", EN_ALL, CL_NONE, 1'b0, 16'd0);

    // Load-use, default single bubble
    @(negedge CLK); set_haz_rn(1'b1);
    chk(0, "lu_rn", EN_HAZ, CL_IDEX, 1'b0, 16'd0);
    @(negedge CLK); idle();
    chk(0, "lu_after", EN_ALL, CL_NONE, 1'b0, 16'd1);
    @(negedge CLK); set_haz_rn(1'b0);
    chk(0, "lu_nouse", EN_ALL, CL_NONE, 1'b0, 16'd1);
    @(negedge CLK); idle();
    EX_LOAD = 1'b1; EX_RF_ENABLE = 1'b1; EX_RD = 4'd15; ID_RN = 4'd5; ID_RM = 4'd15; ID_USES_RN = 1'b1; ID_USES_RM = 1'b1;
    chk(0, "lu_rm_r15", EN_HAZ, CL_IDEX, 1'b0, 16'd1);
    @(negedge CLK); EX_RF_ENABLE = 1'b0;
    chk(0, "lu_norf", EN_ALL, CL_NONE, 1'b0, 16'd2);

    // Three-cycle load-use; hazard and branch ignored in LOAD_STALL
    do_reset();
    @(negedge CLK); set_haz_rn(1'b1);
    chk(1, "l3_b1", EN_HAZ, CL_IDEX, 1'b0, 16'd0);
    @(negedge CLK); BRANCH_TAKEN = 1'b1;
    chk(1, "l3_b2_br", EN_HAZ, CL_IDEX, 1'b0, 16'd1);
    @(negedge CLK); BRANCH_TAKEN = 1'b0;
    chk(1, "l3_b3", EN_HAZ, CL_IDEX, 1'b0, 16'd2);
    @(negedge CLK); idle();
    chk(1, "l3_after", EN_ALL, CL_NONE, 1'b0, 16'd3);

    // Memory wait, completes after 5 stall cycles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); MEM_ACCESS = 1'b1; MEM_MOC = 1'b0;
      chk(0, "mw_wait", EN_NONE, CL_NONE, 1'b0, 16'(i));
    end
    @(negedge CLK); MEM_MOC = 1'b1;
    chk(0, "mw_moc", EN_ALL, CL_NONE, 1'b0, 16'd5);
    @(negedge CLK); idle();
    chk(0, "mw_after", EN_ALL, CL_NONE, 1'b0, 16'd5);

    // Timeout fault with MEM_TIMEOUT=4, cleared only by reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); MEM_ACCESS = 1'b1; MEM_MOC = 1'b0;
      chk(2, "to_wait", EN_NONE, CL_NONE, 1'b0, 16'(i));
    end
    @(negedge CLK);
    chk(2, "to_fault", EN_NONE, CL_NONE, 1'b1, 16'd5);
    @(negedge CLK); MEM_MOC = 1'b1; MEM_ACCESS = 1'b0;
    chk(2, "to_sticky", EN_NONE, CL_NONE, 1'b1, 16'd6);
    @(negedge CLK); RESET = 1'b1; idle();
    chk(2, "to_rst", EN_NONE, CL_RST, 1'b1, 16'd7);
    @(negedge CLK); RESET = 1'b0;
    chk(2, "to_cleared", EN_ALL, CL_NONE, 1'b0, 16'd0);

    // Completion on the timeout cycle wins over the fault
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); MEM_ACCESS = 1'b1; MEM_MOC = 1'b0;
    end
    @(negedge CLK); MEM_MOC = 1'b1;
    chk(2, "to_moc_edge", EN_ALL, CL_NONE, 1'b0, 16'd4);
    @(negedge CLK); idle();
    chk(2, "to_moc_after", EN_ALL, CL_NONE, 1'b0, 16'd4);

    // Hazard beats branch; branch alone flushes; memory beats both
    do_reset();
    @(negedge CLK); set_haz_rn(1'b1); BRANCH_TAKEN = 1'b1;
    chk(0, "hb_both", EN_HAZ, CL_IDEX, 1'b0, 16'd0);
    @(negedge CLK); idle(); BRANCH_TAKEN = 1'b1;
    chk(0, "hb_branch", EN_ALL, CL_IFID, 1'b0, 16'd1);
    @(negedge CLK); set_haz_rn(1'b1); MEM_ACCESS = 1'b1; MEM_MOC = 1'b0;
    chk(0, "pri_mem", EN_NONE, CL_NONE, 1'b0, 16'd1);
    @(negedge CLK); BRANCH_TAKEN = 1'b0; MEM_MOC = 1'b1;
    chk(0, "moc_haz", EN_HAZ, CL_IDEX, 1'b0, 16'd2);
    @(negedge CLK); idle();
    chk(0, "moc_haz_after", EN_ALL, CL_NONE, 1'b0, 16'd3);

    // Saturation: 66 accesses of 1000 stall cycles each
    do_reset();
    for (int it = 0; it < 66; it++) begin
      @(negedge CLK); MEM_ACCESS = 1'b1; MEM_MOC = 1'b0;
      repeat (999) @(negedge CLK);
      @(negedge CLK); MEM_MOC = 1'b1;
      if (it == 0) chk(3, "sat_1k", EN_ALL, CL_NONE, 1'b0, 16'd1000);
    end
    @(negedge CLK); MEM_MOC = 1'b0;
    chk(3, "sat_full", EN_NONE, CL_NONE, 1'b0, 16'hFFFF);
    @(negedge CLK);
    chk(3, "sat_hold", EN_NONE, CL_NONE, 1'b0, 16'hFFFF);
    @(negedge CLK); RESET = 1'b1;
    chk(3, "sat_rst", EN_NONE, CL_RST, 1'b0, 16'hFFFF);
    @(negedge CLK); RESET = 1'b0; idle();
    chk(3, "sat_run", EN_ALL, CL_NONE, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Drives the ENABLE and bubble-clear inputs of the 64-bit pipeline control registers and the PC register.
- Detects load-use hazards, flushes the wrong-path instruction on a taken branch, and freezes the pipeline while a memory access awaits MEM_MOC.
- Enforces a memory timeout fault.
- Keeps a saturating stall-cycle performance counter.

Parameters:
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 64, MEM_WAIT cycles before MEM_FAULT (2..1023)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous, active-high reset
ID_RN, ID_RM  input  4  source registers of instruction in ID
ID_USES_RN, ID_USES_RM  input  1  source actually read
EX_LOAD  input  1  instruction in EX is a load
EX_RF_ENABLE  input  1  instruction in EX writes register file
EX_RD  input  4  destination of instruction in EX
BRANCH_TAKEN  input  1  branch resolved taken in ID this cycle
MEM_ACCESS  input  1  MEM stage holds a load/store
MEM_MOC  input  1  memory operation complete
PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE  output  1  register enables
IF_ID_CLEAR, ID_EX_CLEAR  output  1  bubble insert, wired to the register's RESET
MEM_FAULT  output  1  sticky timeout flag
STALL_CYCLES  output  16  saturating count of cycles with PC_ENABLE=0

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RESET is synchronous and active-high: sampled on the rising CLK edge only.
  - RESET=1 at an edge sets state RUN, stall counter 0, wait counter 0, MEM_FAULT 0, STALL_CYCLES 0.
  - RESET is honoured mid-operation in any state, including FAULT.
- Outputs while RESET=1: all enables 0, both clears 1.
- State register: RUN, LOAD_STALL, MEM_WAIT, FAULT.
- Output decoding:
  - Outputs are combinational from the current state and inputs.
  - State and counters are registered.
  - Default: all enables 1, clears 0.
- Hazard term: HAZ = EX_LOAD & EX_RF_ENABLE & ((ID_USES_RN & ID_RN==EX_RD) | (ID_USES_RM & ID_RM==EX_RD)). R15 is not special.
- Priority in RUN: memory wait > load-use > branch.
- RUN:
  - MEM_ACCESS & !MEM_MOC: all enables 0, clears 0; next MEM_WAIT, wait counter=1, stall counter unchanged.
  - Else HAZ: PC_ENABLE=0, IF_ID_ENABLE=0, ID_EX_CLEAR=1, other enables 1, IF_ID_CLEAR=0. Next LOAD_STALL with stall counter=LOAD_USE_CYCLES-1 if LOAD_USE_CYCLES>1, else stay RUN.
  - Else BRANCH_TAKEN: IF_ID_CLEAR=1, all enables 1.
  - MEM_ACCESS & MEM_MOC: normal default outputs.
- LOAD_STALL:
  - Same outputs as the RUN hazard case. HAZ and BRANCH_TAKEN are ignored.
  - Stall counter decrements each cycle; at 1 the next state is RUN.
  - MEM_ACCESS & !MEM_MOC takes priority: freeze, next MEM_WAIT, stall counter held.
- MEM_WAIT:
  - While MEM_MOC=0: all enables 0, clears 0; wait counter increments.
  - MEM_MOC=1: the current cycle uses normal RUN decoding except the memory term. Next state is LOAD_STALL if stall counter>0, else RUN. Wait counter is cleared.
  - If MEM_MOC=0 and wait counter==MEM_TIMEOUT: next FAULT, MEM_FAULT set.
  - MOC on the timeout cycle wins: no fault.
- FAULT: all enables 0, clears 0, MEM_FAULT=1 until RESET.
- STALL_CYCLES: +1 on every non-reset edge where PC_ENABLE=0; saturates at 16'hFFFF with no wrap.
- Simultaneous HAZ and BRANCH_TAKEN: the hazard wins. The branch re-resolves next cycle with ID held.

Test Plan:
- RESET high 2 cycles, then low with idle inputs -> during reset enables 0 and clears 1; after reset all enables 1, STALL_CYCLES=0, MEM_FAULT=0.
- EX_LOAD=1, EX_RF_ENABLE=1, EX_RD=3, ID_RN=3, ID_USES_RN=1 for one cycle (default params) -> that cycle PC_ENABLE=0, IF_ID_ENABLE=0, ID_EX_CLEAR=1; next cycle all enables 1; STALL_CYCLES=1. Repeat with ID_USES_RN=0 -> no stall.
- LOAD_USE_CYCLES=3 with the same hazard -> 3 consecutive bubble cycles, STALL_CYCLES=3; HAZ held high throughout is ignored after cycle 1.
- MEM_ACCESS=1, MEM_MOC low 5 cycles then high -> enables 0 for 5 cycles, 1 on the MOC cycle, STALL_CYCLES=5. Same test with MEM_TIMEOUT=4 and MOC never asserted -> MEM_FAULT rises after 4 wait cycles; all enables stay 0 until RESET clears.
- HAZ and BRANCH_TAKEN in the same cycle -> IF_ID_CLEAR=0, ID_EX_CLEAR=1. Next cycle BRANCH_TAKEN alone -> IF_ID_CLEAR=1, enables 1.
- Force 65536 stall cycles via MEM_WAIT with large MEM_TIMEOUT -> STALL_CYCLES holds 16'hFFFF; RESET mid-MEM_WAIT returns to RUN next cycle.
